// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store master between the multicycle datapath and a req/gnt + rvalid bus.
// Optional feature macro MEM_MISALIGNED_EN: allow misaligned accesses, split into two beats when crossing a word.
module mem_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        req_valid_i,
   input  logic        req_we_i,
   input  logic [1:0]  req_size_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        busy_o,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_rdata_o,
   output logic        err_o,
   output logic        bus_req_o,
   input  logic        bus_gnt_i,
   output logic [31:0] bus_addr_o,
   output logic        bus_we_o,
   output logic [3:0]  bus_be_o,
   output logic [31:0] bus_wdata_o,
   input  logic        bus_rvalid_i,
   input  logic [31:0] bus_rdata_i
);

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   localparam int unsigned      WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WD_W-1:0]  WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic             WD_EN   = (TIMEOUT_CYCLES != 0);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ADDR0 = 3'd1,
      ST_DATA0 = 3'd2,
      ST_ADDR1 = 3'd3,
      ST_DATA1 = 3'd4,
      ST_RESP  = 3'd5
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;
   logic [31:0]       addr_r;
   logic [31:0]       wdata_r;
   logic [31:0]       beat0_r;
   logic [31:0]       rdata_r;
   logic [1:0]        size_r;
   logic              we_r;
   logic              err_r;
   logic [WD_W-1:0]   wdog_r;

   logic              legal_s;
   logic              split_s;
   logic              busy_s;
   logic              bus_req_s;
   logic              beat1_s;
   logic              wd_hit_s;
   logic              timeout_s;
   logic [1:0]        off_s;
   logic [3:0]        nbytes_s;
   logic [7:0]        be_s;
   logic [63:0]       wdata_wide_s;

   function automatic logic [3:0] size_bytes(input logic [1:0] size);
      case (size)
         SIZE_BYTE: size_bytes = 4'd1;
         SIZE_HALF: size_bytes = 4'd2;
         SIZE_WORD: size_bytes = 4'd4;
         default:   size_bytes = 4'd0;
      endcase
   endfunction

   // Two beats are concatenated as beat1:beat0 before the shift, so one extractor serves both cases.
   function automatic logic [31:0] extract_rdata(input logic [63:0] raw, input logic [1:0] off,
                                                 input logic [3:0] nbytes);
      logic [31:0] mask;
      case (nbytes)
         4'd1:    mask = 32'h0000_00FF;
         4'd2:    mask = 32'h0000_FFFF;
         4'd4:    mask = 32'hFFFF_FFFF;
         default: mask = 32'h0000_0000;
      endcase
      extract_rdata = 32'(raw >> {off, 3'b000}) & mask;
   endfunction

   // Legality of the request being presented; only consulted in IDLE.
   always_comb begin
      legal_s = 1'b0;
      case (req_size_i)
`ifdef MEM_MISALIGNED_EN
         SIZE_BYTE, SIZE_HALF, SIZE_WORD: legal_s = 1'b1;
`else
         SIZE_BYTE: legal_s = 1'b1;
         SIZE_HALF: legal_s = ~req_addr_i[0];
         SIZE_WORD: legal_s = (req_addr_i[1:0] == 2'b00);
`endif
         default:   legal_s = 1'b0;
      endcase
   end

   // Lane steering for the latched access; upper byte-enable nibble belongs to beat 1.
   always_comb begin
      off_s        = addr_r[1:0];
      nbytes_s     = size_bytes(size_r);
      be_s         = ((8'd1 << nbytes_s) - 8'd1) << off_s;
      wdata_wide_s = {32'd0, wdata_r} << {off_s, 3'b000};
`ifdef MEM_MISALIGNED_EN
      split_s      = |be_s[7:4];
`else
      split_s      = 1'b0;
`endif
   end

   // Next-state logic; a handshake in the watchdog's last cycle still wins over the timeout.
   always_comb begin
      state_nxt_s = state_r;
      timeout_s   = 1'b0;
      wd_hit_s    = WD_EN && (wdog_r == WD_LAST);
      case (state_r)
         ST_IDLE: begin
            if (req_valid_i) begin
               state_nxt_s = legal_s ? ST_ADDR0 : ST_RESP;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ADDR0, ST_ADDR1: begin
            if (bus_gnt_i) begin
               state_nxt_s = (state_r == ST_ADDR0) ? ST_DATA0 : ST_DATA1;
            end else if (wd_hit_s) begin
               state_nxt_s = ST_RESP;
               timeout_s   = 1'b1;
            end else begin
               state_nxt_s = state_r;
            end
         end
         ST_DATA0: begin
            if (bus_rvalid_i) begin
               state_nxt_s = split_s ? ST_ADDR1 : ST_RESP;
            end else if (wd_hit_s) begin
               state_nxt_s = ST_RESP;
               timeout_s   = 1'b1;
            end else begin
               state_nxt_s = ST_DATA0;
            end
         end
         ST_DATA1: begin
            if (bus_rvalid_i) begin
               state_nxt_s = ST_RESP;
            end else if (wd_hit_s) begin
               state_nxt_s = ST_RESP;
               timeout_s   = 1'b1;
            end else begin
               state_nxt_s = ST_DATA1;
            end
         end
         ST_RESP: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Watchdog: restarts on every state change, counts while waiting on the bus.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wdog_r <= {WD_W{1'b0}};
      end else if (!WD_EN || (state_nxt_s != state_r)) begin
         wdog_r <= {WD_W{1'b0}};
      end else if (busy_s) begin
         wdog_r <= wdog_r + WD_W'(1);
      end else begin
         wdog_r <= wdog_r;
      end
   end

   // Request capture, read-data merge and response flags; rdata/err are only non-zero in RESP.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         addr_r  <= 32'd0;
         wdata_r <= 32'd0;
         size_r  <= 2'd0;
         we_r    <= 1'b0;
         beat0_r <= 32'd0;
         rdata_r <= 32'd0;
         err_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               rdata_r <= 32'd0;
               if (req_valid_i) begin
                  addr_r  <= req_addr_i;
                  wdata_r <= req_wdata_i;
                  size_r  <= req_size_i;
                  we_r    <= req_we_i;
                  err_r   <= ~legal_s;
               end else begin
                  err_r   <= 1'b0;
               end
            end
            ST_ADDR0, ST_ADDR1: begin
               if (timeout_s) begin
                  err_r <= 1'b1;
               end
            end
            ST_DATA0: begin
               if (bus_rvalid_i) begin
                  beat0_r <= bus_rdata_i;
                  rdata_r <= (we_r || split_s) ? 32'd0
                             : extract_rdata({32'd0, bus_rdata_i}, off_s, nbytes_s);
               end else if (timeout_s) begin
                  err_r <= 1'b1;
               end
            end
            ST_DATA1: begin
               if (bus_rvalid_i) begin
                  rdata_r <= we_r ? 32'd0 : extract_rdata({bus_rdata_i, beat0_r}, off_s, nbytes_s);
               end else if (timeout_s) begin
                  err_r <= 1'b1;
               end
            end
            ST_RESP: begin
               rdata_r <= 32'd0;
               err_r   <= 1'b0;
            end
            default: begin
               rdata_r <= 32'd0;
               err_r   <= 1'b0;
            end
         endcase
      end
   end

   assign busy_s    = (state_r != ST_IDLE) && (state_r != ST_RESP);
   assign bus_req_s = (state_r == ST_ADDR0) || (state_r == ST_ADDR1);
   assign beat1_s   = (state_r == ST_ADDR1);

   assign busy_o      = busy_s;
   assign rsp_valid_o = (state_r == ST_RESP);
   assign rsp_rdata_o = rdata_r;
   assign err_o       = err_r;
   assign bus_req_o   = bus_req_s;
   assign bus_addr_o  = bus_req_s ? ({addr_r[31:2], 2'b00} + (beat1_s ? 32'd4 : 32'd0)) : 32'd0;
   assign bus_we_o    = bus_req_s & we_r;
   assign bus_be_o    = bus_req_s ? (beat1_s ? be_s[7:4] : be_s[3:0]) : 4'd0;
   assign bus_wdata_o = (bus_req_s && we_r) ? (beat1_s ? wdata_wide_s[63:32] : wdata_wide_s[31:0])
                                            : 32'd0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized accesses against a
// transaction-level model (lane masks by arithmetic, bus slave with chosen per-phase delays).
module tb_mem_access_unit;

   localparam int TMO = 8;
`ifdef MEM_MISALIGNED_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        req_valid_i;
   logic        req_we_i;
   logic [1:0]  req_size_i;
   logic [31:0] req_addr_i;
   logic [31:0] req_wdata_i;
   logic        busy_o;
   logic        rsp_valid_o;
   logic [31:0] rsp_rdata_o;
   logic        err_o;
   logic        bus_req_o;
   logic        bus_gnt_i;
   logic [31:0] bus_addr_o;
   logic        bus_we_o;
   logic [3:0]  bus_be_o;
   logic [31:0] bus_wdata_o;
   logic        bus_rvalid_i;
   logic [31:0] bus_rdata_i;

   int n_checks = 0;
   int n_fail   = 0;

   logic [1:0]  rnd_size;
   logic [31:0] rnd_addr;

   mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .req_valid_i  (req_valid_i),
      .req_we_i     (req_we_i),
      .req_size_i   (req_size_i),
      .req_addr_i   (req_addr_i),
      .req_wdata_i  (req_wdata_i),
      .busy_o       (busy_o),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_rdata_o  (rsp_rdata_o),
      .err_o        (err_o),
      .bus_req_o    (bus_req_o),
      .bus_gnt_i    (bus_gnt_i),
      .bus_addr_o   (bus_addr_o),
      .bus_we_o     (bus_we_o),
      .bus_be_o     (bus_be_o),
      .bus_wdata_o  (bus_wdata_o),
      .bus_rvalid_i (bus_rvalid_i),
      .bus_rdata_i  (bus_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic int rnd_delay();
      return ($urandom_range(0, 15) == 0) ? 40 : int'($urandom_range(0, 3));
   endfunction

   // One access: gdX/rdX are the cycles the slave waits before gnt/rvalid on beat X.
   task automatic run_txn(input logic we, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input int gd0, input int rd0,
                          input int gd1, input int rd1, input logic [31:0] r0, input logic [31:0] r1);
      int          n, off, phase, beat, cnt, gd, rd;
      bit          legal, split, tmo, hs, done;
      logic [7:0]  be8;
      logic [63:0] w64, rd64;
      logic [31:0] exp_rd;
      n      = 1 << size;
      off    = int'(addr[1:0]);
      legal  = MIS_EN || (size == 2'd0) || (size == 2'd1 && !addr[0]) ||
               (size == 2'd2 && addr[1:0] == 2'd0);
      split  = legal && (off + n > 4);
      be8    = 8'(((1 << n) - 1) << off);
      w64    = {32'd0, wdata} << (8 * off);
      rd64   = ({r1, r0} >> (8 * off)) & ((64'd1 << (8 * n)) - 64'd1);
      exp_rd = we ? 32'd0 : rd64[31:0];

      req_valid_i = 1'b1;
      req_we_i    = we;
      req_size_i  = size;
      req_addr_i  = addr;
      req_wdata_i = wdata;
      @(posedge clk_i);
      phase = legal ? 0 : 2;
      beat  = 0;
      cnt   = 0;
      tmo   = 1'b0;
      done  = 1'b0;
      for (int k = 1; k <= 8 * TMO + 16 && !done; k++) begin
         @(negedge clk_i);
         req_valid_i  = 1'b0;
         req_we_i     = 1'($urandom_range(0, 1));
         req_size_i   = 2'($urandom_range(0, 2));
         req_addr_i   = $urandom();
         req_wdata_i  = $urandom();
         bus_gnt_i    = 1'b0;
         bus_rvalid_i = 1'b0;
         bus_rdata_i  = $urandom();
         if (phase == 2) begin
            check("rsp_valid", rsp_valid_o, 32'd1);
            check("rsp_err", err_o, tmo || !legal);
            check("rsp_rdata", rsp_rdata_o, (tmo || !legal) ? 32'd0 : exp_rd);
            check("rsp_busy", busy_o, 32'd0);
            check("rsp_bus_req", bus_req_o, 32'd0);
            req_valid_i = 1'b1;
            done = 1'b1;
         end else begin
            check("busy", busy_o, 32'd1);
            check("rsp_early", rsp_valid_o, 32'd0);
            gd = (beat == 1) ? gd1 : gd0;
            rd = (beat == 1) ? rd1 : rd0;
            if (phase == 0) begin
               check("bus_req", bus_req_o, 32'd1);
               check("bus_addr", bus_addr_o, {addr[31:2], 2'b00} + 32'(4 * beat));
               check("bus_be", bus_be_o, (beat == 1) ? be8[7:4] : be8[3:0]);
               check("bus_we", bus_we_o, we);
               if (we) check("bus_wdata", bus_wdata_o, (beat == 1) ? w64[63:32] : w64[31:0]);
               hs           = (cnt == gd);
               bus_gnt_i    = hs;
               bus_rvalid_i = 1'($urandom_range(0, 1));
            end else begin
               check("bus_req_data", bus_req_o, 32'd0);
               hs           = (cnt == rd);
               bus_rvalid_i = hs;
               if (hs) bus_rdata_i = (beat == 1) ? r1 : r0;
               bus_gnt_i    = 1'($urandom_range(0, 1));
            end
            if (hs) begin
               cnt = 0;
               if (phase == 0) begin
                  phase = 1;
               end else if (beat == 0 && split) begin
                  phase = 0;
                  beat  = 1;
               end else begin
                  phase = 2;
               end
            end else if (cnt + 1 == TMO) begin
               phase = 2;
               tmo   = 1'b1;
            end else begin
               cnt++;
            end
         end
      end
      check("txn_done", done, 32'd1);
      // Request held during RESP must not be taken: the unit is idle afterwards.
      @(negedge clk_i);
      req_valid_i  = 1'b0;
      bus_gnt_i    = 1'b0;
      bus_rvalid_i = 1'($urandom_range(0, 1));
      check("idle_busy", busy_o, 32'd0);
      check("idle_bus_req", bus_req_o, 32'd0);
      check("idle_rsp", rsp_valid_o, 32'd0);
      check("idle_err", err_o, 32'd0);
      check("idle_rdata", rsp_rdata_o, 32'd0);
   endtask

   // Abandon a load via reset, either waiting in ADDR0 or in DATA0.
   task automatic abort_with_reset(input bit in_data);
      req_valid_i = 1'b1;
      req_we_i    = 1'b0;
      req_size_i  = 2'd2;
      req_addr_i  = 32'h0000_0200;
      @(posedge clk_i);
      @(negedge clk_i);
      req_valid_i  = 1'b0;
      bus_rvalid_i = 1'b0;
      bus_gnt_i    = in_data;
      if (in_data) begin
         @(negedge clk_i);
         bus_gnt_i = 1'b0;
         check("rst_pre_busy", busy_o, 32'd1);
      end else begin
         check("rst_pre_req", bus_req_o, 32'd1);
      end
      reset_i = 1'b1;
      #1;
      check("rst_busy", busy_o, 32'd0);
      check("rst_bus_req", bus_req_o, 32'd0);
      check("rst_rsp", rsp_valid_o, 32'd0);
      @(negedge clk_i);
      reset_i      = 1'b0;
      bus_rvalid_i = 1'b1;
      bus_rdata_i  = $urandom();
      @(negedge clk_i);
      bus_rvalid_i = 1'b0;
      check("spur_busy", busy_o, 32'd0);
      check("spur_rsp", rsp_valid_o, 32'd0);
   endtask

   initial begin
      reset_i      = 1'b1;
      req_valid_i  = 1'b0;
      req_we_i     = 1'b0;
      req_size_i   = 2'd0;
      req_addr_i   = 32'd0;
      req_wdata_i  = 32'd0;
      bus_gnt_i    = 1'b0;
      bus_rvalid_i = 1'b0;
      bus_rdata_i  = 32'd0;
      #2;
      check("reset_busy", busy_o, 32'd0);
      check("reset_rsp", rsp_valid_o, 32'd0);
      check("reset_err", err_o, 32'd0);
      check("reset_rdata", rsp_rdata_o, 32'd0);
      check("reset_bus_req", bus_req_o, 32'd0);
      check("reset_bus_addr", bus_addr_o, 32'd0);
      check("reset_bus_be", bus_be_o, 32'd0);
      check("reset_bus_we", bus_we_o, 32'd0);
      check("reset_bus_wdata", bus_wdata_o, 32'd0);
      repeat (2) @(negedge clk_i);
      reset_i = 1'b0;
      @(negedge clk_i);

      run_txn(1'b0, 2'd2, 32'h0000_0100, 32'h0, 0, 0, 0, 0, 32'hDEAD_BEEF, 32'h0);
      run_txn(1'b0, 2'd0, 32'h0000_0103, 32'h0, 0, 0, 0, 0, 32'h80AA_BBCC, 32'h0);
      run_txn(1'b1, 2'd0, 32'h0000_0101, 32'h0000_005A, 0, 0, 0, 0, 32'h0, 32'h0);
      run_txn(1'b1, 2'd2, 32'h0000_0102, 32'h1122_3344, 0, 0, 0, 0, 32'h0, 32'h0);
      run_txn(1'b0, 2'd1, 32'h0000_0103, 32'h0, 1, 2, 1, 0, 32'hAABB_CCDD, 32'h1122_3344);
      run_txn(1'b0, 2'd1, 32'h0000_0306, 32'h0, 0, 1, 0, 0, 32'hCAFE_F00D, 32'h0);
      run_txn(1'b0, 2'd2, 32'h0000_0040, 32'h0, 5, 0, 0, 0, 32'h1357_9BDF, 32'h0);
      run_txn(1'b1, 2'd2, 32'h0000_0044, 32'h0BAD_F00D, 1000, 0, 0, 0, 32'h0, 32'h0);
      run_txn(1'b0, 2'd2, 32'h0000_0048, 32'h0, 0, 1000, 0, 0, 32'h2468_ACE0, 32'h0);
      run_txn(1'b0, 2'd2, 32'h0000_004A, 32'h0, 0, 0, 1000, 0, 32'h5555_AAAA, 32'h0);
      run_txn(1'b0, 2'd2, 32'h0000_0050, 32'h0, TMO - 1, TMO - 1, 0, 0, 32'h7777_1111, 32'h0);

      abort_with_reset(1'b1);
      run_txn(1'b0, 2'd2, 32'h0000_0200, 32'h0, 0, 0, 0, 0, 32'h0123_4567, 32'h0);
      abort_with_reset(1'b0);
      run_txn(1'b1, 2'd1, 32'h0000_0202, 32'hFFFF_9876, 1, 1, 0, 0, 32'h0, 32'h0);

      for (int i = 0; i < 80; i++) begin
         rnd_size = 2'($urandom_range(0, 2));
         rnd_addr = $urandom();
         if ($urandom_range(0, 1) == 0) rnd_addr = rnd_addr & ~((32'd1 << rnd_size) - 32'd1);
         run_txn(1'($urandom_range(0, 1)), rnd_size, rnd_addr, $urandom(),
                 rnd_delay(), rnd_delay(), rnd_delay(), rnd_delay(), $urandom(), $urandom());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not reach the summary");
      $fatal(1);
   end

endmodule
